// File: rtl/qdec_pkg.sv
// Shared types and helpers for the quadrature step decoder.
package qdec_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {INIT, TRACK} qdec_state_t;

    localparam logic [3:0] POS_MAX = 4'd9;
    localparam logic [3:0] POS_MIN = 4'd0;

    // UP successor in the Gray order 00 -> 01 -> 11 -> 10 -> 00, phase as {b,a}.
    function automatic phase_t next_up(phase_t p);
        phase_t n;
        case (p)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/qdec_sync2.sv
// Single-bit two-flop synchronizer, asynchronously reset to 0.
module qdec_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // Next values of the two synchronizer stages.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronizes A/B, decodes Gray transitions into
// step/up_down pulses, keeps a MOD-10 position and a sticky illegal-jump flag.
// Optional stability filter enabled by defining QDEC_GLITCH_FILTER_EN.
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       err_clr,
    output logic       step,
    output logic       up_down,
    output logic [3:0] pos,
    output logic       err
);

    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("quad_step_decoder: FILTER_LEN must be in 2..15");
    end

    logic   a_s, b_s;
    phase_t sync_ph;
    phase_t acc_ph;

    qdec_sync2 u_sync_a (.clk(clk), .reset(reset), .d(a_in), .q(a_s));
    qdec_sync2 u_sync_b (.clk(clk), .reset(reset), .d(b_in), .q(b_s));

    assign sync_ph = {b_s, a_s};

    qdec_state_t state_q, state_d;

`ifdef QDEC_GLITCH_FILTER_EN
    // INIT lasts until the filter has passed the real post-reset level through.
    localparam logic [1:0] WARM_LAST = 2'd3;
    localparam logic [3:0] FLT_LAST  = 4'(FILTER_LEN - 1);

    phase_t     acc_q, acc_d;
    phase_t     cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;

    // Stability filter: accept a differing candidate after FILTER_LEN equal samples.
    // During INIT the synchronizer level is adopted directly so no step is faked.
    always_comb begin
        acc_d  = acc_q;
        cand_d = sync_ph;
        cnt_d  = cnt_q;
        if (state_q == INIT) begin
            acc_d = sync_ph;
            cnt_d = 4'd0;
        end else if (sync_ph == acc_q) begin
            cnt_d = 4'd0;
        end else if (sync_ph != cand_q || cnt_q == 4'd0) begin
            cnt_d = 4'd1;
        end else if (cnt_q == FLT_LAST) begin
            acc_d = sync_ph;
            cnt_d = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Filter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= 2'b00;
            cand_q <= 2'b00;
            cnt_q  <= 4'd0;
        end else begin
            acc_q  <= acc_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    assign acc_ph = acc_q;
`else
    // INIT lasts until the synchronizer holds the real post-reset level.
    localparam logic [1:0] WARM_LAST = 2'd2;

    assign acc_ph = sync_ph;
`endif

    logic [1:0] warm_q, warm_d;
    phase_t     ref_q, ref_d;
    logic       step_q, step_d;
    logic       up_q, up_d;
    logic [3:0] pos_q, pos_d;
    logic       err_q, err_d;

    function automatic logic [3:0] pos_inc(logic [3:0] p);
        return (p >= POS_MAX) ? POS_MIN : p + 4'd1;
    endfunction

    function automatic logic [3:0] pos_dec(logic [3:0] p);
        return (p == POS_MIN || p > POS_MAX) ? POS_MAX : p - 4'd1;
    endfunction

    // Decode FSM: adopt the reference in INIT, then classify each change in TRACK.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        ref_d   = ref_q;
        step_d  = 1'b0;
        up_d    = up_q;
        pos_d   = pos_q;
        err_d   = err_q & ~err_clr;
        case (state_q)
            INIT: begin
                ref_d  = acc_ph;
                warm_d = warm_q + 2'd1;
                if (warm_q == WARM_LAST) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (acc_ph != ref_q) begin
                    ref_d = acc_ph;
                    if (acc_ph == next_up(ref_q)) begin
                        step_d = 1'b1;
                        up_d   = 1'b1;
                        pos_d  = pos_inc(pos_q);
                    end else if (ref_q == next_up(acc_ph)) begin
                        step_d = 1'b1;
                        up_d   = 1'b0;
                        pos_d  = pos_dec(pos_q);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Decode and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            warm_q  <= 2'd0;
            ref_q   <= 2'b00;
            step_q  <= 1'b0;
            up_q    <= 1'b1;
            pos_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            ref_q   <= ref_d;
            step_q  <= step_d;
            up_q    <= up_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    assign step    = step_q;
    assign up_down = up_q;
    assign pos     = pos_q;
    assign err     = err_q;

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

Quadrature step decoder that converts two asynchronous phase inputs, A and B from a rotary or linear encoder, into the one-cycle `step` pulse and `up_down` direction level that drive the MOD-10 bidirectional counters. It also keeps its own MOD-10 position, so a bench can cross-check it against a downstream counter. It flags illegal phase jumps with a sticky error bit.

## Interface
- `FILTER_LEN`, default 4: consecutive clock edges a new A/B value must hold before it is accepted. Legal range 2..15. Used only when the filter is compiled in.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_in`  in  1  encoder phase A; asynchronous to `clk`.
- `b_in`  in  1  encoder phase B; asynchronous to `clk`.
- `err_clr`  in  1  synchronous clear of `err`.
- `step`  out  1  one-cycle pulse per accepted legal transition.
- `up_down`  out  1  direction of the last legal transition: 1 = UP, 0 = DOWN.
- `pos`  out  4  MOD-10 position, range 0..9.
- `err`  out  1  sticky illegal-transition flag.

## Operation
- `a_in` and `b_in` each pass through a 2-flop synchronizer.
- The synchronized pair forms a 2-bit phase vector `{b,a}`.
- Gray order for UP is 00 → 01 → 11 → 10 → 00. The reverse order is DOWN.
- Decode state machine has two states:
  - INIT: entered on reset. The first phase vector accepted after reset is loaded as the reference phase. No `step` is generated. Move to TRACK.
  - TRACK: compare each accepted vector with the reference.
    - Equal: no action.
    - One-bit change: `step`=1 for one cycle, `up_down` set to the decoded direction, `pos` updated, reference updated.
    - Two-bit change (e.g. 00 → 11): `err` set, no `step`, `pos` and `up_down` unchanged, reference updated to the new vector.
- `pos` arithmetic:
  - UP at 9 wraps to 0; otherwise +1.
  - DOWN at 0 wraps to 9; otherwise −1.
  - `pos` never holds 10..15.
- `up_down` holds its value between steps.
- `err_clr` clears `err` at the next edge. If an illegal transition occurs in the same cycle, set wins and `err` stays 1.
- Reset values: `step`=0, `up_down`=1, `pos`=0, `err`=0, synchronizers 00, filter counter 0, state INIT.
- Reset asserted mid-operation returns to INIT immediately and discards any in-flight filter candidate.

## Timing
- Edge 0 is the first rising edge at which synchronizer stage 1 captures a new input value.
- Without the filter:
  - Stage 2 updates at edge 1.
  - The decode register updates at edge 2.
  - `step`, `up_down` and `pos` change at edge 2. `step` is high for exactly the cycle between edge 2 and edge 3.
- With the filter:
  - The accepted vector updates at edge 1+`FILTER_LEN`.
  - Outputs update at edge 2+`FILTER_LEN`.
- Maximum legal step rate is one accepted transition per decode cycle. Back-to-back accepted transitions produce `step` high on consecutive cycles, one pulse each.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `QDEC_GLITCH_FILTER_EN`.
- Defined:
  - A stability filter sits between the synchronizer and the decoder.
  - A candidate vector is accepted only after it is unchanged for `FILTER_LEN` consecutive edges while differing from the accepted vector.
  - Any change of candidate restarts the count. A candidate equal to the accepted vector holds the count at 0.
  - Pulses shorter than `FILTER_LEN` cycles are invisible at the outputs.
- Undefined:
  - The synchronizer output feeds the decoder directly.
  - `FILTER_LEN` is ignored.
  - Latency is 2 edges.

## Structure
- Package `qdec_pkg` holds:
  - `typedef logic [1:0] phase_t`
  - `typedef enum logic {INIT, TRACK} qdec_state_t`
  - localparams `POS_MAX` = 4'd9 and `POS_MIN` = 4'd0
  - a function `next_up(phase_t)` returning the UP successor in the Gray order
- Sub-module `qdec_sync2` is a single-bit 2-flop synchronizer with asynchronous reset to 0. It is instantiated twice.

## Test plan
- Reset, hold A=B=0 for 10 cycles → `step` stays 0, `pos`=0, `up_down`=1, `err`=0. State reaches TRACK with no pulse.
- Drive 12 UP transitions (00 → 01 → 11 → 10 → …), each held ≥ `FILTER_LEN`+2 cycles → 12 single-cycle `step` pulses, `up_down`=1, `pos` sequence 1..9, 0, 1, 2.
- From `pos`=0, drive 3 DOWN transitions → `up_down`=0, `pos` sequence 9, 8, 7. Each `step` appears exactly at edge 2+`FILTER_LEN` after capture (edge 2 without the filter).
- From phase 00, jump to 11 → `err`=1, no `step`, `pos` unchanged. Pulse `err_clr` → `err`=0 next edge. A second illegal jump in the same cycle as `err_clr` → `err` stays 1.
- With `QDEC_GLITCH_FILTER_EN`, pulse A for `FILTER_LEN`−1 cycles → no `step`, `pos` unchanged. Hold the change for `FILTER_LEN` cycles → one `step`.
- Assert `reset` while a filter candidate is pending and after 4 steps → all outputs return to reset values next cycle. After release, the current A/B level is adopted with no `step`.
